trigger_sequencer_of_verifla: RTL and testbench

Multi-stage trigger sequencer that drives the capture monitor's run and trigger inputs. It issues the run request, waits for the monitor to arm, then walks up to 4 ordered match stages on the qualified sample stream. On the final stage it fires the monitor's external trigger. Sits between the host command decoder, the probed data bus and the monitor.

---
 rtl/trigger_sequencer_of_verifla_if.sv | 40 ++++
 rtl/trigger_sequencer_of_verifla.sv | 241 ++++++++++++++++++++++++
 tb/tb_trigger_sequencer_of_verifla.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_sequencer_of_verifla_if.sv
// Host/probe/monitor-facing signal bundle of the VeriFLA trigger sequencer.
// Pure wiring: no latency of its own.
// slave = sequencer view, master = host/monitor/testbench view; no flow control of its own.
interface trigger_sequencer_of_verifla_if #(
  parameter int DATA_W = 32
);
  // qualified sample stream from the probed bus
  logic              cqual_i;
  logic [DATA_W-1:0] data_in_i;
  // host configuration and control
  logic              cfg_we_i;
  logic [1:0]        cfg_stage_i;
  logic [1:0]        cfg_field_i;
  logic [DATA_W-1:0] cfg_wdata_i;
  logic              start_i;
  logic              abort_i;
  // monitor status in, monitor control out
  logic              mon_armed_i;
  logic              mon_triggered_i;
  logic              mon_run_o;
  logic              trigqual_o;
  logic              exttrig_o;
  // sequencer status
  logic              busy_o;
  logic [1:0]        stage_idx_o;
  logic              fired_o;
  logic              timed_out_o;

  modport slave (
    input  cqual_i, data_in_i, cfg_we_i, cfg_stage_i, cfg_field_i, cfg_wdata_i,
           start_i, abort_i, mon_armed_i, mon_triggered_i,
    output mon_run_o, trigqual_o, exttrig_o, busy_o, stage_idx_o, fired_o, timed_out_o
  );

  modport master (
    output cqual_i, data_in_i, cfg_we_i, cfg_stage_i, cfg_field_i, cfg_wdata_i,
           start_i, abort_i, mon_armed_i, mon_triggered_i,
    input  mon_run_o, trigqual_o, exttrig_o, busy_o, stage_idx_o, fired_o, timed_out_o
  );
endinterface

// File: rtl/trigger_sequencer_of_verifla.sv
// Multi-stage (up to 4) trigger sequencer driving the VeriFLA monitor run/exttrig inputs.
// Latency: exttrig rises 1 clk after the qualifying final-stage sample; all outputs registered.
// Config writes and start are ignored while busy; TRIGSEQ_TIMEOUT_EN enables the inter-stage timeout.
module trigger_sequencer_of_verifla #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 24
) (
  input  logic                         clk,
  input  logic                         rst_l,
  trigger_sequencer_of_verifla_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_MATCH,
    ST_FIRE,
    ST_DONE
  } state_t;

  // The global config word packs the timeout above the 2-bit stage count,
  // and the count field is taken from the low bits of the write data.
  if (TMO_W + 2 > DATA_W) begin : g_chk_tmo_w
    $error("trigger_sequencer_of_verifla: TMO_W+2 must not exceed DATA_W");
  end
  if (CNT_W > DATA_W) begin : g_chk_cnt_w
    $error("trigger_sequencer_of_verifla: CNT_W must not exceed DATA_W");
  end

  // configuration registers
  logic [DATA_W-1:0] mask_q  [4];
  logic [DATA_W-1:0] value_q [4];
  logic [CNT_W-1:0]  count_q [4];
  logic [1:0]        nstg_q;        // number of stages minus one
`ifdef TRIGSEQ_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tcnt_q;
  logic [TMO_W-1:0]  tcnt_d;
  logic              tmo_hit;
  logic              timed_out_q;
`endif

  // sequencer state and registered outputs
  state_t            state_q;
  logic [CNT_W-1:0]  hits_q;
  logic [1:0]        stage_q;
  logic              mon_run_q;
  logic              exttrig_q;
  logic              busy_q;
  logic              fired_q;

  // current-stage comparison
  logic [DATA_W-1:0] cur_mask;
  logic [DATA_W-1:0] cur_value;
  logic [CNT_W-1:0]  cur_count;
  logic [CNT_W-1:0]  need_cnt;
  logic [CNT_W-1:0]  hits_d;
  logic              stage_hit;
  logic              stage_done;
  logic              last_stage;

  assign cur_mask   = mask_q[stage_q];
  assign cur_value  = value_q[stage_q];
  assign cur_count  = count_q[stage_q];
  // a programmed count of zero behaves as a single occurrence
  assign need_cnt   = (cur_count == '0) ? CNT_W'(1) : cur_count;
  // hit counter saturates instead of wrapping
  assign hits_d     = (&hits_q) ? hits_q : hits_q + CNT_W'(1);
  assign stage_hit  = bus.cqual_i &&
                      ((bus.data_in_i & cur_mask) == (cur_value & cur_mask));
  assign stage_done = stage_hit && (hits_d == need_cnt);
  assign last_stage = (stage_q == nstg_q);

`ifdef TRIGSEQ_TIMEOUT_EN
  // stage 0 never times out; a zero timeout disables the restart
  assign tcnt_d  = tcnt_q + TMO_W'(1);
  assign tmo_hit = bus.cqual_i && (stage_q != 2'd0) && (tmo_q != '0) &&
                   (tcnt_d == tmo_q);
`endif

  // host config writes, only accepted while the sequencer is idle
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 4; i++) begin
        mask_q[i]  <= '0;
        value_q[i] <= '0;
        count_q[i] <= CNT_W'(1);
      end
      nstg_q <= 2'd0;
`ifdef TRIGSEQ_TIMEOUT_EN
      tmo_q  <= '0;
`endif
    end else if (bus.cfg_we_i && (state_q == ST_IDLE)) begin
      case (bus.cfg_field_i)
        2'd0: mask_q[bus.cfg_stage_i]  <= bus.cfg_wdata_i;
        2'd1: value_q[bus.cfg_stage_i] <= bus.cfg_wdata_i;
        2'd2: count_q[bus.cfg_stage_i] <= bus.cfg_wdata_i[CNT_W-1:0];
        2'd3: begin
          nstg_q <= bus.cfg_wdata_i[1:0];
`ifdef TRIGSEQ_TIMEOUT_EN
          tmo_q  <= bus.cfg_wdata_i[TMO_W+1:2];
`endif
        end
        default: ;
      endcase
    end
  end

  // run/arm handshake, ordered stage walk and exttrig handshake with the monitor
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= ST_IDLE;
      hits_q      <= '0;
      stage_q     <= 2'd0;
      mon_run_q   <= 1'b0;
      exttrig_q   <= 1'b0;
      busy_q      <= 1'b0;
      fired_q     <= 1'b0;
`ifdef TRIGSEQ_TIMEOUT_EN
      tcnt_q      <= '0;
      timed_out_q <= 1'b0;
`endif
    end else if ((state_q != ST_IDLE) && bus.abort_i) begin
      // abort beats everything once a sequence is running; sticky flags survive
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      mon_run_q <= 1'b0;
      exttrig_q <= 1'b0;
      stage_q   <= 2'd0;
      hits_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_q     <= ST_REQ;
            busy_q      <= 1'b1;
            mon_run_q   <= 1'b1;
            fired_q     <= 1'b0;
`ifdef TRIGSEQ_TIMEOUT_EN
            timed_out_q <= 1'b0;
`endif
          end
        end

        ST_REQ: begin
          if (bus.mon_armed_i) begin
            state_q   <= ST_MATCH;
            mon_run_q <= 1'b0;
            hits_q    <= '0;
            stage_q   <= 2'd0;
`ifdef TRIGSEQ_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
          end
        end

        ST_MATCH: begin
          if (!bus.mon_armed_i) begin
            // monitor was reset underneath us
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            stage_q <= 2'd0;
            hits_q  <= '0;
          end else if (stage_done) begin
            if (last_stage) begin
              state_q   <= ST_FIRE;
              exttrig_q <= 1'b1;
              fired_q   <= 1'b1;
            end else begin
              stage_q <= stage_q + 2'd1;
              hits_q  <= '0;
`ifdef TRIGSEQ_TIMEOUT_EN
              tcnt_q  <= '0;
`endif
            end
          end
`ifdef TRIGSEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            stage_q     <= 2'd0;
            hits_q      <= '0;
            tcnt_q      <= '0;
            timed_out_q <= 1'b1;
          end
`endif
          else if (bus.cqual_i) begin
            // occurrences need not be consecutive: misses keep the count
            if (stage_hit) begin
              hits_q <= hits_d;
            end
`ifdef TRIGSEQ_TIMEOUT_EN
            if ((stage_q != 2'd0) && (tmo_q != '0)) begin
              tcnt_q <= tcnt_d;
            end
`endif
          end
        end

        ST_FIRE: begin
          if (!bus.mon_armed_i) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            exttrig_q <= 1'b0;
          end else if (bus.mon_triggered_i) begin
            state_q   <= ST_DONE;
            exttrig_q <= 1'b0;
          end
        end

        ST_DONE: begin
          // wait for the monitor to finish readout and disarm
          if (!bus.mon_armed_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          mon_run_q <= 1'b0;
          exttrig_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mon_run_o   = mon_run_q;
  // the monitor's own comparator must never trigger by itself
  assign bus.trigqual_o  = 1'b0;
  assign bus.exttrig_o   = exttrig_q;
  assign bus.busy_o      = busy_q;
  assign bus.stage_idx_o = stage_q;
  assign bus.fired_o     = fired_q;
`ifdef TRIGSEQ_TIMEOUT_EN
  assign bus.timed_out_o = timed_out_q;
`else
  assign bus.timed_out_o = 1'b0;
`endif

endmodule

// File: tb/tb_trigger_sequencer_of_verifla.sv
// Self-checking bench for trigger_sequencer_of_verifla: vector table plus directed corner sequences.
// Inputs driven 1 time unit after the rising edge, outputs sampled 1 time unit after the next one.
// The bench plays host and monitor; expected stage/exttrig values are queued per driven sample.
module tb_trigger_sequencer_of_verifla;

`ifdef TRIGSEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst_l;

  trigger_sequencer_of_verifla_if #(.DATA_W(32)) bus ();

  trigger_sequencer_of_verifla #(
    .DATA_W(32),
    .CNT_W (16),
    .TMO_W (24)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  typedef struct {
    logic        cq;
    logic [31:0] dat;
    logic [1:0]  stg;
    logic        ext;
  } vec_t;

  vec_t vecs [17];
  vec_t sb_q [$];
  vec_t exp_v;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] st, input logic [1:0] fld, input logic [31:0] dat);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_stage_i = st;
    bus.cfg_field_i = fld;
    bus.cfg_wdata_i = dat;
    tick();
    bus.cfg_we_i    = 1'b0;
  endtask

  // start pulse, monitor arms three clocks after mon_run rises
  task automatic start_arm(input string tag);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk_b({tag, " mon_run up"}, bus.mon_run_o, 1'b1);
    chk_b({tag, " busy up"}, bus.busy_o, 1'b1);
    tick();
    tick();
    bus.mon_armed_i = 1'b1;
    tick();
    chk_b({tag, " mon_run dropped"}, bus.mon_run_o, 1'b0);
    chk_v({tag, " stage at arm"}, 32'(bus.stage_idx_o), 32'd0);
    chk_b({tag, " exttrig at arm"}, bus.exttrig_o, 1'b0);
  endtask

  // monitor acknowledges the trigger, then disarms after readout
  task automatic finish_run(input string tag);
    bus.mon_triggered_i = 1'b1;
    tick();
    chk_b({tag, " exttrig dropped"}, bus.exttrig_o, 1'b0);
    bus.mon_triggered_i = 1'b0;
    bus.mon_armed_i     = 1'b0;
    tick();
    chk_b({tag, " idle after disarm"}, bus.busy_o, 1'b0);
  endtask

  task automatic drive(input logic cq, input logic [31:0] dat);
    bus.cqual_i   = cq;
    bus.data_in_i = dat;
    tick();
    bus.cqual_i   = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // stimulus table: 10 unqualified copies of a matching word, a qualified
    // miss, then the 01,02,07,02,03 walk over stages with counts 1/2/1
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b0, 32'h01, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 32'h02, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 32'h01, 2'd1, 1'b0};
    vecs[12] = '{1'b1, 32'h02, 2'd1, 1'b0};
    vecs[13] = '{1'b1, 32'h07, 2'd1, 1'b0};
    vecs[14] = '{1'b0, 32'h02, 2'd1, 1'b0};
    vecs[15] = '{1'b1, 32'h02, 2'd2, 1'b0};
    vecs[16] = '{1'b1, 32'h03, 2'd2, 1'b1};

    rst_l               = 1'b0;
    bus.cqual_i         = 1'b0;
    bus.data_in_i       = '0;
    bus.cfg_we_i        = 1'b0;
    bus.cfg_stage_i     = 2'd0;
    bus.cfg_field_i     = 2'd0;
    bus.cfg_wdata_i     = '0;
    bus.start_i         = 1'b0;
    bus.abort_i         = 1'b0;
    bus.mon_armed_i     = 1'b0;
    bus.mon_triggered_i = 1'b0;
    tick();
    tick();

    // reset values
    chk_b("rst mon_run", bus.mon_run_o, 1'b0);
    chk_b("rst trigqual", bus.trigqual_o, 1'b0);
    chk_b("rst exttrig", bus.exttrig_o, 1'b0);
    chk_b("rst busy", bus.busy_o, 1'b0);
    chk_v("rst stage_idx", 32'(bus.stage_idx_o), 32'd0);
    chk_b("rst fired", bus.fired_o, 1'b0);
    chk_b("rst timed_out", bus.timed_out_o, 1'b0);
    rst_l = 1'b1;
    tick();

    // single stage, count left at its reset value of 1
    cfg_write(2'd0, 2'd0, 32'hFF);
    cfg_write(2'd0, 2'd1, 32'h5A);
    start_arm("t1");
    drive(1'b1, 32'h5A);
    chk_b("t1 exttrig 1clk after match", bus.exttrig_o, 1'b1);
    chk_b("t1 fired", bus.fired_o, 1'b1);
    chk_v("t1 stage_idx", 32'(bus.stage_idx_o), 32'd0);
    chk_b("t1 trigqual", bus.trigqual_o, 1'b0);
    finish_run("t1");

    // three stages from the table
    cfg_write(2'd0, 2'd1, 32'h01);
    cfg_write(2'd1, 2'd0, 32'hFF);
    cfg_write(2'd1, 2'd1, 32'h02);
    cfg_write(2'd1, 2'd2, 32'd2);
    cfg_write(2'd2, 2'd0, 32'hFF);
    cfg_write(2'd2, 2'd1, 32'h03);
    cfg_write(2'd0, 2'd3, 32'd2);
    start_arm("t2");
    chk_b("t2 fired cleared by start", bus.fired_o, 1'b0);
    for (int i = 0; i < 17; i++) begin
      bus.cqual_i   = vecs[i].cq;
      bus.data_in_i = vecs[i].dat;
      sb_q.push_back(vecs[i]);
      tick();
      exp_v = sb_q.pop_front();
      chk_v($sformatf("vec%0d stage_idx", i), 32'(bus.stage_idx_o), 32'(exp_v.stg));
      chk_b($sformatf("vec%0d exttrig", i), bus.exttrig_o, exp_v.ext);
    end
    bus.cqual_i = 1'b0;
    finish_run("t2");

    // abort while sitting in stage 1, then a config write must land
    start_arm("t4");
    drive(1'b1, 32'h01);
    chk_v("t4 reached stage 1", 32'(bus.stage_idx_o), 32'd1);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk_b("t4 abort busy", bus.busy_o, 1'b0);
    chk_b("t4 abort exttrig", bus.exttrig_o, 1'b0);
    chk_v("t4 abort stage_idx", 32'(bus.stage_idx_o), 32'd0);
    chk_b("t4 abort mon_run", bus.mon_run_o, 1'b0);
    bus.mon_armed_i = 1'b0;
    cfg_write(2'd0, 2'd1, 32'h11);
    cfg_write(2'd0, 2'd2, 32'd0);
    cfg_write(2'd0, 2'd3, 32'd0);

    // config ignored while busy, count 0 acts as 1, exttrig held 5 clk
    start_arm("t5");
    cfg_write(2'd0, 2'd1, 32'h77);
    drive(1'b1, 32'h77);
    chk_b("t5 busy write ignored", bus.exttrig_o, 1'b0);
    chk_v("t5 stage after miss", 32'(bus.stage_idx_o), 32'd0);
    drive(1'b1, 32'h11);
    chk_b("t5 exttrig on written value", bus.exttrig_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_b($sformatf("t5 exttrig held %0d", i + 2), bus.exttrig_o, 1'b1);
    end
    bus.mon_triggered_i = 1'b1;
    tick();
    bus.mon_triggered_i = 1'b0;
    chk_b("t5 exttrig released", bus.exttrig_o, 1'b0);
    chk_b("t5 done busy", bus.busy_o, 1'b1);
    tick();
    chk_b("t5 done waits for disarm", bus.busy_o, 1'b1);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk_b("t5 abort in done", bus.busy_o, 1'b0);
    chk_b("t5 fired kept over abort", bus.fired_o, 1'b1);
    bus.mon_armed_i = 1'b0;

    // start/abort priorities and monitor disarm mid-match
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk_b("t6 start wins in idle", bus.busy_o, 1'b1);
    chk_b("t6 start clears fired", bus.fired_o, 1'b0);
    tick();
    chk_b("t6 start while busy", bus.mon_run_o, 1'b1);
    bus.abort_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    chk_b("t6 abort wins when busy", bus.busy_o, 1'b0);
    chk_b("t6 abort drops mon_run", bus.mon_run_o, 1'b0);
    start_arm("t6");
    bus.mon_armed_i = 1'b0;
    tick();
    chk_b("t6 disarm in match", bus.busy_o, 1'b0);
    chk_b("t6 disarm exttrig", bus.exttrig_o, 1'b0);

    // two stages, timeout 4 qualified samples in stage 1
    cfg_write(2'd0, 2'd1, 32'h01);
    cfg_write(2'd0, 2'd2, 32'd1);
    cfg_write(2'd1, 2'd2, 32'd1);
    cfg_write(2'd0, 2'd3, (32'd4 << 2) | 32'd1);
    start_arm("t7");
    drive(1'b1, 32'h01);
    chk_v("t7 stage 1", 32'(bus.stage_idx_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h09);
      chk_v($sformatf("t7 miss %0d stage", i + 1), 32'(bus.stage_idx_o), 32'd1);
      chk_b($sformatf("t7 miss %0d timed_out", i + 1), bus.timed_out_o, 1'b0);
    end
    drive(1'b1, 32'h09);
    chk_v("t7 4th miss stage", 32'(bus.stage_idx_o), TMO_EN ? 32'd0 : 32'd1);
    chk_b("t7 4th miss timed_out", bus.timed_out_o, TMO_EN);
    drive(1'b1, 32'h01);
    chk_v("t7 back in stage 1", 32'(bus.stage_idx_o), 32'd1);
    drive(1'b1, 32'h02);
    chk_b("t7 sequence completes", bus.exttrig_o, 1'b1);
    chk_b("t7 timed_out sticky", bus.timed_out_o, TMO_EN);
    finish_run("t7");
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    chk_b("t7 start clears timed_out", bus.timed_out_o, 1'b0);

    // asynchronous reset mid-run also restores config (mask 0, one stage)
    #3;
    rst_l = 1'b0;
    #1;
    chk_b("t8 async rst busy", bus.busy_o, 1'b0);
    chk_b("t8 async rst mon_run", bus.mon_run_o, 1'b0);
    tick();
    rst_l = 1'b1;
    tick();
    start_arm("t8");
    drive(1'b1, 32'hDEADBEEF);
    chk_b("t8 mask 0 matches any", bus.exttrig_o, 1'b1);
    finish_run("t8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
